// File: rtl/traffic_phase_controller.sv
// Two-way intersection phase sequencer with per-phase tick countdown and pedestrian truncation.
// Optional night flashing mode is compiled in with `define NIGHT_FLASH_EN.
module traffic_phase_controller #(
  parameter int T_GREEN  = 20,
  parameter int T_YELLOW = 3,
  parameter int T_RED    = 2,
  parameter int PED_CUT  = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       ped_req,
  input  logic       night,
  output logic [2:0] phase,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic [4:0] duration,
  output logic [4:0] remaining,
  output logic       phase_done,
  output logic       ped_ack
);

`ifdef NIGHT_FLASH_EN
  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    RED_A = 3'd2,
    EW_G  = 3'd3,
    EW_Y  = 3'd4,
    RED_B = 3'd5,
    FLASH = 3'd6
  } phase_e;
`else
  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    RED_A = 3'd2,
    EW_G  = 3'd3,
    EW_Y  = 3'd4,
    RED_B = 3'd5
  } phase_e;

  logic unused_night;
  assign unused_night = night;
`endif

  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;

  // Out-of-range parameters are forced into the 5-bit 1..31 counter range.
  function automatic logic [4:0] clamp_dur(input int v);
    if (v < 1)       return 5'd1;
    else if (v > 31) return 5'd31;
    else             return v[4:0];
  endfunction

  localparam logic [4:0] DUR_G   = clamp_dur(T_GREEN);
  localparam logic [4:0] DUR_Y   = clamp_dur(T_YELLOW);
  localparam logic [4:0] DUR_R   = clamp_dur(T_RED);
  localparam logic [4:0] CUT_REM = clamp_dur(PED_CUT);

  function automatic phase_e next_phase(input phase_e p);
    case (p)
      NS_G:    return NS_Y;
      NS_Y:    return RED_A;
      RED_A:   return EW_G;
      EW_G:    return EW_Y;
      EW_Y:    return RED_B;
      default: return NS_G;
    endcase
  endfunction

  function automatic logic [4:0] phase_dur(input phase_e p);
    case (p)
      NS_G, EW_G:   return DUR_G;
      NS_Y, EW_Y:   return DUR_Y;
      RED_A, RED_B: return DUR_R;
      default:      return 5'd1;
    endcase
  endfunction

  function automatic logic [2:0] ns_decode(input phase_e p);
    case (p)
      NS_G:    return LT_GRN;
      NS_Y:    return LT_YEL;
      default: return LT_RED;
    endcase
  endfunction

  function automatic logic [2:0] ew_decode(input phase_e p);
    case (p)
      EW_G:    return LT_GRN;
      EW_Y:    return LT_YEL;
      default: return LT_RED;
    endcase
  endfunction

  function automatic logic is_green(input phase_e p);
    return (p == NS_G) || (p == EW_G);
  endfunction

  function automatic logic is_yellow(input phase_e p);
    return (p == NS_Y) || (p == EW_Y);
  endfunction

  phase_e     phase_q, phase_d, nxt;
  logic [4:0] rem_q, rem_d;
  logic [4:0] dur_q, dur_d;
  logic [2:0] ns_q, ns_d;
  logic [2:0] ew_q, ew_d;
  logic       done_q, done_d;
  logic       ack_q, ack_d;
  logic       pend_q, pend_d;

  always_comb begin
    nxt     = next_phase(phase_q);
    phase_d = phase_q;
    rem_d   = rem_q;
    dur_d   = dur_q;
    ns_d    = ns_q;
    ew_d    = ew_q;
    done_d  = 1'b0;
    ack_d   = 1'b0;
    // A new request always survives a same-cycle clear.
    pend_d  = pend_q | ped_req;

    if (tick) begin
`ifdef NIGHT_FLASH_EN
      if (phase_q == FLASH) begin
        if (!night) begin
          phase_d = RED_B;
          rem_d   = DUR_R;
          dur_d   = DUR_R;
          ns_d    = LT_RED;
          ew_d    = LT_RED;
        end else begin
          ns_d = ns_q ^ LT_YEL;
          ew_d = ew_q ^ LT_YEL;
        end
      end else
`endif
      if (rem_q == 5'd1) begin
`ifdef NIGHT_FLASH_EN
        if (phase_q == RED_B && night) begin
          phase_d = FLASH;
          rem_d   = 5'd1;
          dur_d   = 5'd1;
          ns_d    = LT_YEL;
          ew_d    = LT_YEL;
          done_d  = 1'b1;
        end else
`endif
        begin
          phase_d = nxt;
          rem_d   = phase_dur(nxt);
          dur_d   = phase_dur(nxt);
          ns_d    = ns_decode(nxt);
          ew_d    = ew_decode(nxt);
          done_d  = 1'b1;
          if (is_yellow(nxt) && pend_q) begin
            ack_d  = 1'b1;
            pend_d = ped_req;
          end
        end
      end else if (is_green(phase_q) && pend_q && (rem_q > CUT_REM)) begin
        rem_d  = CUT_REM;
        ack_d  = 1'b1;
        pend_d = ped_req;
      end else begin
        rem_d = rem_q - 5'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= RED_B;
      rem_q   <= DUR_R;
      dur_q   <= DUR_R;
      ns_q    <= LT_RED;
      ew_q    <= LT_RED;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      rem_q   <= rem_d;
      dur_q   <= dur_d;
      ns_q    <= ns_d;
      ew_q    <= ew_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
      pend_q  <= pend_d;
    end
  end

  assign phase      = phase_q;
  assign remaining  = rem_q;
  assign duration   = dur_q;
  assign ns_light   = ns_q;
  assign ew_light   = ew_q;
  assign phase_done = done_q;
  assign ped_ack    = ack_q;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Bench for traffic_phase_controller: vector table, corner-case sequences and a randomized run
// against a phase-index/countdown reference model.
module tb_traffic_phase_controller;

  logic       clk, reset, tick, ped_req, night;
  logic [2:0] phase, ns_light, ew_light;
  logic [4:0] duration, remaining;
  logic       phase_done, ped_ack;

  int checks   = 0;
  int failures = 0;

  traffic_phase_controller dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .ped_req    (ped_req),
    .night      (night),
    .phase      (phase),
    .ns_light   (ns_light),
    .ew_light   (ew_light),
    .duration   (duration),
    .remaining  (remaining),
    .phase_done (phase_done),
    .ped_ack    (ped_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

  // Reference model: phase index 0..5, ticks left, pending flag.
  int durtab [6] = '{20, 3, 2, 20, 3, 2};
  int nstab  [6] = '{1, 2, 4, 4, 4, 4};
  int ewtab  [6] = '{4, 4, 4, 1, 2, 4};
  int m_phase, m_rem;
  bit m_pend, m_done, m_ack;

  task automatic model_reset();
    m_phase = 5; m_rem = 2; m_pend = 0; m_done = 0; m_ack = 0;
  endtask

  task automatic model_step(input bit t, input bit p);
    bit np;
    np = m_pend | p;
    m_done = 0;
    m_ack  = 0;
    if (t) begin
      if (m_rem == 1) begin
        m_phase = (m_phase + 1) % 6;
        m_rem   = durtab[m_phase];
        m_done  = 1;
        if ((m_phase == 1 || m_phase == 4) && m_pend) begin
          m_ack = 1;
          np    = p;
        end
      end else if ((m_phase == 0 || m_phase == 3) && m_pend && m_rem > 5) begin
        m_rem = 5;
        m_ack = 1;
        np    = p;
      end else begin
        m_rem = m_rem - 1;
      end
    end
    m_pend = np;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic cmp_model();
    chk("phase", int'(phase), m_phase);
    chk("remaining", int'(remaining), m_rem);
    chk("duration", int'(duration), durtab[m_phase]);
    chk("ns_light", int'(ns_light), nstab[m_phase]);
    chk("ew_light", int'(ew_light), ewtab[m_phase]);
    chk("phase_done", int'(phase_done), int'(m_done));
    chk("ped_ack", int'(ped_ack), int'(m_ack));
    chk("never_both_go", int'(ns_light != 3'b100 && ew_light != 3'b100), 0);
  endtask

  task automatic cyc(input bit t, input bit p);
    tick = t;
    ped_req = p;
    @(posedge clk);
    model_step(t, p);
    #1;
    cmp_model();
  endtask

  task automatic raw(input bit t);
    tick = t;
    ped_req = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic adv_to(input int ph, input int rm);
    int n;
    n = 0;
    while (!(int'(phase) == ph && int'(remaining) == rm) && n < 200) begin
      cyc(1, 0);
      n++;
    end
    if (n >= 200) chk($sformatf("adv_to_timeout_p%0d_r%0d", ph, rm), 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    model_reset();
  endtask

  typedef struct {
    bit t;
    bit p;
    int ph;
    int rem;
    bit done;
    bit ack;
  } vec_t;

  vec_t vt [12];

  initial begin
    int n, cnt, prev;
    bit started;

    vt[0]  = '{0, 0, 5, 2, 0, 0};
    vt[1]  = '{1, 0, 5, 1, 0, 0};
    vt[2]  = '{1, 0, 0, 20, 1, 0};
    vt[3]  = '{0, 0, 0, 20, 0, 0};
    vt[4]  = '{1, 0, 0, 19, 0, 0};
    vt[5]  = '{0, 1, 0, 19, 0, 0};
    vt[6]  = '{1, 0, 0, 5, 0, 1};
    vt[7]  = '{1, 0, 0, 4, 0, 0};
    vt[8]  = '{1, 0, 0, 3, 0, 0};
    vt[9]  = '{1, 0, 0, 2, 0, 0};
    vt[10] = '{1, 0, 0, 1, 0, 0};
    vt[11] = '{1, 0, 1, 3, 1, 0};

    reset = 1; tick = 0; ped_req = 0; night = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_phase", int'(phase), 5);
    chk("rst_remaining", int'(remaining), 2);
    chk("rst_duration", int'(duration), 2);
    chk("rst_ns", int'(ns_light), 4);
    chk("rst_ew", int'(ew_light), 4);
    chk("rst_done", int'(phase_done), 0);
    chk("rst_ack", int'(ped_ack), 0);
    @(negedge clk);
    reset = 0;

    // Vector table from reset through a truncated NS green.
    for (int i = 0; i < 12; i++) begin
      cyc(vt[i].t, vt[i].p);
      chk($sformatf("vec%0d_phase", i), int'(phase), vt[i].ph);
      chk($sformatf("vec%0d_rem", i), int'(remaining), vt[i].rem);
      chk($sformatf("vec%0d_done", i), int'(phase_done), int'(vt[i].done));
      chk($sformatf("vec%0d_ack", i), int'(ped_ack), int'(vt[i].ack));
    end

    // Full cycles with a tick every clk: measure each phase length and order.
    started = 0; cnt = 0; prev = int'(phase);
    for (int i = 0; i < 110; i++) begin
      cyc(1, 0);
      if (int'(phase) != prev) begin
        chk("phase_order", int'(phase), (prev + 1) % 6);
        if (started) chk($sformatf("len_phase%0d", prev), cnt, durtab[prev]);
        started = 1;
        cnt = 1;
        prev = int'(phase);
      end else begin
        cnt++;
      end
    end

    // NS green at 15: a pulse truncates to 5, NS_Y follows 5 ticks later.
    adv_to(0, 15);
    cyc(0, 1);
    cyc(1, 0);
    chk("ns_trunc_rem", int'(remaining), 5);
    chk("ns_trunc_ack", int'(ped_ack), 1);
    n = 0;
    while (int'(phase) != 1 && n < 20) begin
      cyc(1, 0);
      n++;
    end
    chk("ns_trunc_ticks_to_yellow", n, 5);

    // EW green at 3 with request held: no truncation, ack on EW_Y entry.
    adv_to(3, 3);
    n = 0;
    while (int'(phase) != 4 && n < 10) begin
      cyc(1, 1);
      n++;
    end
    chk("ew_late_ticks", n, 3);
    chk("ew_late_ack", int'(ped_ack), 1);
    cyc(1, 0);
    chk("ew_late_ack_pulse", int'(ped_ack), 0);

    // Freeze with tick low for 50 clks.
    adv_to(3, 10);
    for (int i = 0; i < 50; i++) cyc(0, 0);
    chk("freeze_rem", int'(remaining), 10);
    chk("freeze_ns", int'(ns_light), 4);
    chk("freeze_ew", int'(ew_light), 1);

    // Asynchronous reset mid EW_Y with a request pending.
    adv_to(4, 2);
    cyc(0, 1);
    #2;
    reset = 1;
    #1;
    chk("areset_phase", int'(phase), 5);
    chk("areset_rem", int'(remaining), 2);
    chk("areset_dur", int'(duration), 2);
    chk("areset_ns", int'(ns_light), 4);
    chk("areset_ew", int'(ew_light), 4);
    chk("areset_done", int'(phase_done), 0);
    chk("areset_ack", int'(ped_ack), 0);
    @(negedge clk);
    reset = 0;
    model_reset();
    adv_to(0, 20);
    cyc(1, 0);
    chk("areset_pending_dropped", int'(remaining), 19);

`ifdef NIGHT_FLASH_EN
    adv_to(5, 1);
    night = 1;
    raw(1);
    chk("flash_phase", int'(phase), 6);
    chk("flash_ns_on", int'(ns_light), 2);
    chk("flash_ew_on", int'(ew_light), 2);
    chk("flash_dur", int'(duration), 1);
    raw(1);
    chk("flash_ns_off", int'(ns_light), 0);
    chk("flash_ew_off", int'(ew_light), 0);
    chk("flash_done_low", int'(phase_done), 0);
    raw(0);
    chk("flash_hold", int'(ns_light), 0);
    raw(1);
    chk("flash_ns_on2", int'(ns_light), 2);
    night = 0;
    raw(1);
    chk("flash_exit_phase", int'(phase), 5);
    chk("flash_exit_rem", int'(remaining), 2);
    chk("flash_exit_ns", int'(ns_light), 4);
    chk("flash_exit_done", int'(phase_done), 0);
    raw(1);
    raw(1);
    chk("flash_resume_phase", int'(phase), 0);
    chk("flash_resume_done", int'(phase_done), 1);
    do_reset();
`else
    // night has no effect in this build.
    adv_to(5, 1);
    night = 1;
    cyc(1, 0);
    chk("night_ignored_phase", int'(phase), 0);
    night = 0;
`endif

    // Randomized ticks and sparse requests against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/traffic_phase_controller.md
Name: traffic_phase_controller

Overview:
Sequences a two-way (NS/EW) intersection through its six light phases and owns the per-phase countdown. Each phase's duration is presented on `duration` so the datapath countdown counter can reload from it. Accepts a 1-cycle `tick` timebase strobe, so the block itself contains no delay statements. Latches pedestrian requests and truncates the current green phase in response.

Parameters:
T_GREEN, 20, ticks per green phase (1..31)
T_YELLOW, 3, ticks per yellow phase (1..31)
T_RED, 2, ticks per all-red clearance phase (1..31)
PED_CUT, 5, remaining green ticks after a pedestrian truncation (1..31)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
tick  input  1  timebase strobe, one clk wide; the timer advances only when tick=1
ped_req  input  1  pedestrian button, level; sampled every clk
night  input  1  night-mode request (used only with NIGHT_FLASH_EN)
phase  output  3  current phase: 0 NS_G, 1 NS_Y, 2 RED_A, 3 EW_G, 4 EW_Y, 5 RED_B
ns_light  output  3  {red,yellow,green}, one-hot
ew_light  output  3  {red,yellow,green}, one-hot
duration  output  5  programmed duration of the current phase (counter reload value)
remaining  output  5  ticks left in the current phase
phase_done  output  1  one-clk pulse on the clk where the phase advances
ped_ack  output  1  one-clk pulse when a pending pedestrian request is serviced

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values:
  - phase=RED_B, remaining=T_RED, duration=T_RED.
  - ns_light=ew_light=3'b100.
  - phase_done=0, ped_ack=0, ped_pending=0.
- Phase order: NS_G -> NS_Y -> RED_A -> EW_G -> EW_Y -> RED_B -> NS_G, wrapping.
- Phase durations:
  - NS_G and EW_G use T_GREEN.
  - NS_Y and EW_Y use T_YELLOW.
  - RED_A and RED_B use T_RED.
  - A parameter value of 0 is treated as 1.
- Timer rules, on each clk with tick=1:
  - If remaining==1: advance the phase, load remaining and duration with the next phase's value, and assert phase_done on that same clk.
  - Otherwise: remaining <= remaining-1.
  - With tick=0, remaining holds.
  - Each phase therefore lasts exactly its duration in ticks.
- Lights are a registered decode of phase:
  - NS_G: ns=001, ew=100.
  - NS_Y: ns=010, ew=100.
  - EW_G: ns=100, ew=001.
  - EW_Y: ns=100, ew=010.
  - RED_A and RED_B: both 100.
  - Both directions are never non-red at the same time.
- Pedestrian handling:
  - ped_pending is set on any clk where ped_req=1.
  - On a tick in NS_G or EW_G with ped_pending=1 and remaining>PED_CUT: remaining <= PED_CUT instead of decrementing. Clear ped_pending and pulse ped_ack.
  - If remaining<=PED_CUT in that case, decrement normally. ped_pending clears, with a ped_ack pulse, on entry to the next yellow phase.
  - ped_req asserted on the same clk as a clear: set wins; the request stays pending.
  - Truncation never lengthens a phase and applies only to green phases.
- Width rules:
  - remaining is 5-bit unsigned.
  - Decrement below 1 is impossible by construction.
  - No wrap-around to 31.
- Reset mid-phase returns immediately to the reset values; pending requests are discarded.

Optional Feature:
Macro NIGHT_FLASH_EN.
- Defined:
  - night=1, sampled at a RED_B->NS_G boundary, enters a seventh phase FLASH (phase=6) instead of NS_G.
  - In FLASH, duration=1 and both lights toggle between 010 and 000 on every tick. phase_done and ped_ack stay 0, and ped_pending is ignored.
  - When night=0 on a tick, the block goes to RED_B with remaining=T_RED, then resumes normal order.
- Undefined: the night input is ignored, phase never equals 6, and the logic is absent.

Test Plan:
- Reset, then 2 ticks -> phase RED_B->NS_G after the 2nd tick; phase_done pulses once; duration=20, ns_light=001, ew_light=100.
- Full cycle with tick every clk and ped_req=0 -> phases 0..5 last 20,3,2,20,3,2 ticks; the sequence repeats; the two directions are never both non-red.
- In NS_G at remaining=15, pulse ped_req -> next tick sets remaining=5 and ped_ack pulses; NS_Y is entered 5 ticks later.
- In EW_G at remaining=3, ped_req held -> normal countdown; ped_ack pulses on entry to EW_Y.
- tick=0 for 50 clks mid-phase -> remaining and lights frozen; assert reset asynchronously mid-EW_Y -> outputs reach reset values without a clk edge.
- (NIGHT_FLASH_EN) night=1 through RED_B end -> phase=6 with lights alternating 010/000 per tick; night=0 -> RED_B for 2 ticks, then NS_G.
